// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Format codes, opcode constants and the stage-1 field bundle.
package inst_encoder_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // True when imm[31:msb] are all copies of one bit.
  function automatic logic imm_fits(
    input logic [31:0] imm,
    input int unsigned msb
  );
    logic [31:0] hi;
    hi = $signed(imm) >>> msb;
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I field packer with immediate range check.
// Illegal formats pack as R and always flag an error.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] inst,
  output logic        err
);

  logic is_r, is_i, is_s, is_b, is_u, is_j;

  assign is_r = (f.fmt == FMT_R);
  assign is_i = (f.fmt == FMT_I);
  assign is_s = (f.fmt == FMT_S);
  assign is_b = (f.fmt == FMT_B);
  assign is_u = (f.fmt == FMT_U);
  assign is_j = (f.fmt == FMT_J);

  always_comb begin
    inst = {f.funct7, f.rs2, f.rs1,
            f.funct3, f.rd, f.opcode};
    err  = 1'b0;
    unique case (1'b1)
      is_r: err = 1'b0;
      is_i: begin
        inst = {f.imm[11:0], f.rs1,
                f.funct3, f.rd, f.opcode};
        err  = !imm_fits(f.imm, 11);
      end
      is_s: begin
        inst = {f.imm[11:5], f.rs2, f.rs1,
                f.funct3, f.imm[4:0], f.opcode};
        err  = !imm_fits(f.imm, 11);
      end
      is_b: begin
        inst = {f.imm[12], f.imm[10:5],
                f.rs2, f.rs1, f.funct3,
                f.imm[4:1], f.imm[11], f.opcode};
        err  = !imm_fits(f.imm, 12) || f.imm[0];
      end
      is_u: begin
        inst = {f.imm[31:12], f.rd, f.opcode};
        err  = (f.imm[11:0] != 12'd0);
      end
      is_j: begin
        inst = {f.imm[20], f.imm[10:1],
                f.imm[11], f.imm[19:12],
                f.rd, f.opcode};
        err  = !imm_fits(f.imm, 20) || f.imm[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder.
// Stage 1 holds raw fields, stage 2 the packed word and error flag.
module inst_encoder #(
  parameter bit DROP_ERR = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);
  import inst_encoder_pkg::*;

  fields_t          in_f;
  fields_t          s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_inst_q, s2_inst_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pk_inst;
  logic             pk_err;
  logic             s1_adv;
  logic             keep;

  assign in_f = '{
    fmt:    in_fmt,
    opcode: in_opcode,
    rd:     in_rd,
    rs1:    in_rs1,
    rs2:    in_rs2,
    funct3: in_funct3,
    funct7: in_funct7,
    imm:    in_imm
  };

  inst_pack u_pack (
    .f    (s1_q),
    .inst (pk_inst),
    .err  (pk_err)
  );

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign keep     = !(DROP_ERR && pk_err);

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s2_inst_d  = s2_inst_q;
    s2_err_d   = s2_err_q;
    cnt_d      = cnt_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = in_f;
    end
    if (s1_adv) begin
      s2_valid_d = s1_valid_q && keep;
      if (s1_valid_q && keep) begin
        s2_inst_d = pk_inst;
        s2_err_d  = pk_err;
      end
    end
    // Counted once, as the entry leaves stage 1.
    if (s1_valid_q && s1_adv && pk_err
        && (cnt_q != '1))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_inst_q  <= s2_inst_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: one forwarding and one dropping instance.
// Inputs and out_ready are shared; outputs are collected per instance.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_ready = 1'b1;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_inst0, out_inst1;
  logic        out_err0, out_err1;
  logic [15:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] q0_inst[$];
  logic        q0_err[$];
  int          q0_cyc[$];
  int          acc0[$];
  logic [31:0] q1_inst[$];

  logic [31:0] exp_b2b [4] = '{
    32'h015A04B3, 32'h0F052483,
    32'h00148493, 32'h06952C23
  };

  always #5 clk = ~clk;

  inst_encoder #(.DROP_ERR(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_inst(out_inst0), .out_err(out_err0),
    .err_count(cnt0)
  );

  inst_encoder #(.DROP_ERR(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_inst(out_inst1), .out_err(out_err1),
    .err_count(cnt1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready0)
      acc0.push_back(cyc);
    if (rst_n && out_valid0 && out_ready) begin
      q0_inst.push_back(out_inst0);
      q0_err.push_back(out_err0);
      q0_cyc.push_back(cyc);
    end
    if (rst_n && out_valid1 && out_ready)
      q1_inst.push_back(out_inst1);
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q0_inst.delete();
    q0_err.delete();
    q0_cyc.delete();
    acc0.delete();
    q1_inst.delete();
  endtask

  task automatic send(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic acc;
    int   k;
    in_fmt = fmt; in_opcode = op;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7;
    in_imm = imm;
    in_valid = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      k++;
    end
    #1;
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected=accept",
             k);
    end
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_out_inst", out_inst0, 32'd0);
    chk("rst_out_err", 32'(out_err0), 32'd0);
    chk("rst_err_count", 32'(cnt0), 32'd0);
    #4 rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready0), 32'd1);

    // Back-to-back stream
    out_ready = 1'b1;
    clear_q();
    send(FMT_R, OP_REG, 5'd9, 5'd20, 5'd21,
         3'd0, 7'd0, 32'd0);
    send(FMT_I, OP_LOAD, 5'd9, 5'd10, 5'd0,
         3'd2, 7'd0, 32'd240);
    send(FMT_I, OP_IMM, 5'd9, 5'd9, 5'd0,
         3'd0, 7'd0, 32'd1);
    send(FMT_S, OP_STORE, 5'd0, 5'd10, 5'd9,
         3'd2, 7'd0, 32'd120);
    in_valid = 1'b0;
    repeat (5) step();
    chk("b2b_count", q0_inst.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_inst%0d", i),
          q0_inst[i], exp_b2b[i]);
      chk($sformatf("b2b_err%0d", i),
          32'(q0_err[i]), 32'd0);
      chk($sformatf("b2b_lat%0d", i),
          q0_cyc[i] - acc0[i], 32'd2);
      chk($sformatf("b2b_rate%0d", i),
          q0_cyc[i] - q0_cyc[0], i);
    end

    // B / J / U formats
    clear_q();
    send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2,
         3'd0, 7'd0, 32'hFFFFFFFC);
    send(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0,
         3'd0, 7'd0, 32'd2048);
    send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0,
         3'd0, 7'd0, 32'h12345000);
    in_valid = 1'b0;
    repeat (5) step();
    chk("bju_count", q0_inst.size(), 32'd3);
    chk("beq_inst", q0_inst[0], 32'hFE208EE3);
    chk("jal_inst", q0_inst[1], 32'h001000EF);
    chk("lui_inst", q0_inst[2], 32'h123452B7);
    chk("bju_err", {q0_err[0], q0_err[1], q0_err[2]}, 32'd0);

    // Range errors, forwarded by u0, dropped by u1
    clear_q();
    send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0,
         3'd0, 7'd0, 32'd2048);
    send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2,
         3'd0, 7'd0, 32'd3);
    send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0,
         3'd0, 7'd0, 32'h00000001);
    send(3'd7, OP_REG, 5'd9, 5'd20, 5'd21,
         3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    repeat (5) step();
    chk("err_count_out", q0_inst.size(), 32'd4);
    chk("err_i_inst", q0_inst[0], 32'h80000093);
    chk("err_b_inst", q0_inst[1], 32'h00208163);
    chk("err_u_inst", q0_inst[2], 32'h000002B7);
    chk("err_f7_inst", q0_inst[3], 32'h015A04B3);
    for (int i = 0; i < 4; i++)
      chk($sformatf("err_flag%0d", i),
          32'(q0_err[i]), 32'd1);
    chk("err_cnt0", 32'(cnt0), 32'd4);
    chk("err_cnt1", 32'(cnt1), 32'd4);
    chk("drop_none_out", q1_inst.size(), 32'd0);

    // Backpressure
    clear_q();
    out_ready = 1'b0;
    send(FMT_I, OP_IMM, 5'd9, 5'd9, 5'd0,
         3'd0, 7'd0, 32'd1);
    send(FMT_I, OP_LOAD, 5'd9, 5'd10, 5'd0,
         3'd2, 7'd0, 32'd240);
    in_fmt = FMT_S; in_opcode = OP_STORE;
    in_rd = 5'd0; in_rs1 = 5'd10; in_rs2 = 5'd9;
    in_funct3 = 3'd2; in_imm = 32'd120;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready0), 32'd0);
    chk("bp_out_valid", 32'(out_valid0), 32'd1);
    chk("bp_inst0", out_inst0, 32'h00148493);
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_ready", 32'(in_ready0), 32'd0);
      chk("bp_hold_inst", out_inst0, 32'h00148493);
    end
    step();
    out_ready = 1'b1;
    send(FMT_S, OP_STORE, 5'd0, 5'd10, 5'd9,
         3'd2, 7'd0, 32'd120);
    send(FMT_R, OP_REG, 5'd9, 5'd20, 5'd21,
         3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    repeat (5) step();
    chk("bp_count", q0_inst.size(), 32'd4);
    chk("bp_out0", q0_inst[0], 32'h00148493);
    chk("bp_out1", q0_inst[1], 32'h0F052483);
    chk("bp_out2", q0_inst[2], 32'h06952C23);
    chk("bp_out3", q0_inst[3], 32'h015A04B3);

    // DROP_ERR: good / bad / good
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    step();
    clear_q();
    send(FMT_I, OP_IMM, 5'd9, 5'd9, 5'd0,
         3'd0, 7'd0, 32'd1);
    send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2,
         3'd0, 7'd0, 32'd3);
    send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0,
         3'd0, 7'd0, 32'h12345000);
    in_valid = 1'b0;
    repeat (5) step();
    chk("drop_count", q1_inst.size(), 32'd2);
    chk("drop_out0", q1_inst[0], 32'h00148493);
    chk("drop_out1", q1_inst[1], 32'h123452B7);
    chk("drop_cnt1", 32'(cnt1), 32'd1);
    chk("fwd_count", q0_inst.size(), 32'd3);
    chk("fwd_err_mid", 32'(q0_err[1]), 32'd1);
    chk("fwd_cnt0", 32'(cnt0), 32'd1);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0,
         3'd0, 7'd0, 32'h00000001);
    send(FMT_I, OP_IMM, 5'd9, 5'd9, 5'd0,
         3'd0, 7'd0, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid0), 32'd1);
    chk("pre_rst_cnt", 32'(cnt0), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid0), 32'd0);
    chk("arst_cnt0", 32'(cnt0), 32'd0);
    chk("arst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    clear_q();
    chk("post_rst_ready", 32'(in_ready0), 32'd1);
    send(FMT_I, OP_IMM, 5'd9, 5'd9, 5'd0,
         3'd0, 7'd0, 32'd1);
    in_valid = 1'b0;
    repeat (5) step();
    chk("post_rst_count", q0_inst.size(), 32'd1);
    chk("post_rst_inst", q0_inst[0], 32'h00148493);
    chk("post_rst_lat", q0_cyc[0] - acc0[0], 32'd2);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
